// File: rtl/llc_cmd_arbiter.sv
// Command sequencer in front of the LLC: CPU holding register plus snoop FIFO,
// snoop-priority arbitration with a CPU anti-starvation streak limit.
// Optional grant/drop counters are enabled by defining LLC_ARB_STATS_EN.
module llc_cmd_arbiter #(
    parameter int CMDSIZE       = 4,
    parameter int ADDR_BITS     = 32,
    parameter int SNP_DEPTH     = 4,
    parameter int MAX_SNP_BURST = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cpu_valid,
    output logic                 cpu_ready,
    input  logic [CMDSIZE-1:0]   cpu_cmd,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    input  logic                 snp_valid,
    output logic                 snp_ready,
    input  logic [CMDSIZE-1:0]   snp_cmd,
    input  logic [ADDR_BITS-1:0] snp_addr,
    output logic [CMDSIZE-1:0]   llc_command,
    output logic [ADDR_BITS-1:0] llc_address,
    output logic                 llc_eof,
    input  logic                 llc_done,
    output logic                 grant_src,
    output logic                 busy,
    output logic                 snp_full,
`ifdef LLC_ARB_STATS_EN
    output logic [31:0]          cpu_grants,
    output logic [31:0]          snp_grants,
    output logic [31:0]          drop_count,
`endif
    output logic                 cmd_err
);

    localparam int PTR_W  = $clog2(SNP_DEPTH);
    localparam int CNT_W  = $clog2(SNP_DEPTH + 1);
    localparam int STRK_W = $clog2(MAX_SNP_BURST + 1);
    localparam int ENT_W  = CMDSIZE + ADDR_BITS;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    function automatic logic cpu_legal(input logic [CMDSIZE-1:0] c);
        return (c == CMDSIZE'(0)) || (c == CMDSIZE'(1)) || (c == CMDSIZE'(2)) ||
               (c == CMDSIZE'(8)) || (c == CMDSIZE'(9));
    endfunction

    function automatic logic snp_legal(input logic [CMDSIZE-1:0] c);
        return (c == CMDSIZE'(3)) || (c == CMDSIZE'(4)) || (c == CMDSIZE'(5)) ||
               (c == CMDSIZE'(6));
    endfunction

    state_t                state_q, state_d;
    logic [CMDSIZE-1:0]    cmd_q, cmd_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic                  src_q, src_d;
    logic [STRK_W-1:0]     streak_q, streak_d;
    logic                  cpu_vld_q, cpu_vld_d;
    logic [CMDSIZE-1:0]    cpu_cmd_q, cpu_cmd_d;
    logic [ADDR_BITS-1:0]  cpu_addr_q, cpu_addr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  err_q, err_d;
    logic [ENT_W-1:0]      fifo_mem_q [SNP_DEPTH];

    logic cpu_acc, snp_acc, cpu_drop, snp_drop, snp_push, snp_pop;
    logic fifo_empty, cpu_is_clear, grant_cpu, grant_snp;

    assign snp_full   = (count_q == CNT_W'(SNP_DEPTH));
    assign snp_ready  = !snp_full;
    assign cpu_ready  = !cpu_vld_q;
    assign fifo_empty = (count_q == '0);

    assign cpu_acc  = cpu_valid && cpu_ready;
    assign snp_acc  = snp_valid && snp_ready;
    assign cpu_drop = cpu_acc && !cpu_legal(cpu_cmd);
    assign snp_drop = snp_acc && !snp_legal(snp_cmd);
    assign snp_push = snp_acc && !snp_drop;

    // Clear/print (8, 9) must wait for a drained FIFO; the streak cannot force them.
    assign cpu_is_clear = (cpu_cmd_q == CMDSIZE'(8)) || (cpu_cmd_q == CMDSIZE'(9));
    assign grant_cpu = (state_q == S_IDLE) && cpu_vld_q &&
                       (fifo_empty || (!cpu_is_clear && streak_q == STRK_W'(MAX_SNP_BURST)));
    assign grant_snp = (state_q == S_IDLE) && !fifo_empty && !grant_cpu;
    assign snp_pop   = grant_snp;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d    = state_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        src_d      = src_q;
        streak_d   = cpu_vld_q ? streak_q : '0;
        cpu_vld_d  = cpu_vld_q;
        cpu_cmd_d  = cpu_cmd_q;
        cpu_addr_d = cpu_addr_q;
        wr_ptr_d   = snp_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = snp_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q + CNT_W'(snp_push) - CNT_W'(snp_pop);
        err_d      = cpu_drop || snp_drop;

        if (cpu_acc && !cpu_drop) begin
            cpu_vld_d  = 1'b1;
            cpu_cmd_d  = cpu_cmd;
            cpu_addr_d = cpu_addr;
        end

        case (state_q)
            S_IDLE: begin
                if (grant_cpu) begin
                    state_d   = S_ISSUE;
                    cmd_d     = cpu_cmd_q;
                    addr_d    = cpu_addr_q;
                    src_d     = 1'b0;
                    cpu_vld_d = 1'b0;
                    streak_d  = '0;
                end else if (grant_snp) begin
                    state_d = S_ISSUE;
                    {cmd_d, addr_d} = fifo_mem_q[rd_ptr_q];
                    src_d   = 1'b1;
                    if (cpu_vld_q && streak_q != STRK_W'(MAX_SNP_BURST))
                        streak_d = streak_q + STRK_W'(1);
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (llc_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            addr_q     <= '0;
            src_q      <= 1'b0;
            streak_q   <= '0;
            cpu_vld_q  <= 1'b0;
            cpu_cmd_q  <= '0;
            cpu_addr_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            src_q      <= src_d;
            streak_q   <= streak_d;
            cpu_vld_q  <= cpu_vld_d;
            cpu_cmd_q  <= cpu_cmd_d;
            cpu_addr_q <= cpu_addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_q      <= err_d;
        end
    end

    // NOTE: FIFO storage is not reset; the count and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (snp_push) fifo_mem_q[wr_ptr_q] <= {snp_cmd, snp_addr};
    end

`ifdef LLC_ARB_STATS_EN
    logic [31:0] cpu_grants_q, cpu_grants_d, snp_grants_q, snp_grants_d;
    logic [31:0] drop_count_q, drop_count_d;

    always_comb begin
        cpu_grants_d = cpu_grants_q + 32'(grant_cpu);
        snp_grants_d = snp_grants_q + 32'(grant_snp);
        drop_count_d = drop_count_q + 32'(cpu_drop) + 32'(snp_drop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_grants_q <= '0;
            snp_grants_q <= '0;
            drop_count_q <= '0;
        end else begin
            cpu_grants_q <= cpu_grants_d;
            snp_grants_q <= snp_grants_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign cpu_grants = cpu_grants_q;
    assign snp_grants = snp_grants_q;
    assign drop_count = drop_count_q;
`endif

    assign llc_command = cmd_q;
    assign llc_address = addr_q;
    assign grant_src   = src_q;
    assign llc_eof     = (state_q == S_ISSUE);
    assign busy        = (state_q != S_IDLE);
    assign cmd_err     = err_q;

endmodule

// File: tb/tb_llc_cmd_arbiter.sv
// Scoreboard bench for llc_cmd_arbiter: expected grants are queued as stimulus
// is driven and compared at each llc_eof; background snoop feeder and LLC responder.
module tb_llc_cmd_arbiter;

    localparam int CW = 4;
    localparam int AW = 32;
    localparam int RW = 2 + CW + AW + 5;

    typedef struct packed {
        logic [CW-1:0] cmd;
        logic [AW-1:0] addr;
        logic          src;
    } grant_t;

    typedef struct packed {
        logic [CW-1:0] cmd;
        logic [AW-1:0] addr;
    } snp_item_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_valid = 1'b0, snp_valid = 1'b0, llc_done = 1'b0;
    logic [CW-1:0] cpu_cmd = '0, snp_cmd = '0;
    logic [AW-1:0] cpu_addr = '0, snp_addr = '0;
    logic          cpu_ready, snp_ready, llc_eof, grant_src, busy, snp_full, cmd_err;
    logic [CW-1:0] llc_command;
    logic [AW-1:0] llc_address;
`ifdef LLC_ARB_STATS_EN
    logic [31:0]   cpu_grants, snp_grants, drop_count;
`endif

    llc_cmd_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_cmd(cpu_cmd), .cpu_addr(cpu_addr),
        .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_cmd(snp_cmd), .snp_addr(snp_addr),
        .llc_command(llc_command), .llc_address(llc_address), .llc_eof(llc_eof),
        .llc_done(llc_done), .grant_src(grant_src), .busy(busy), .snp_full(snp_full),
`ifdef LLC_ARB_STATS_EN
        .cpu_grants(cpu_grants), .snp_grants(snp_grants), .drop_count(drop_count),
`endif
        .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int        checks = 0, failures = 0;
    int        cyc = 0, acc_cyc = 0, eof_cyc = 0, eof_cnt = 0;
    int        done_delay = 1;
    logic      hold = 1'b0;
    grant_t    sb[$];
    snp_item_t snp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Snoop feeder: presents the queue head and holds it until accepted.
    initial begin
        logic tk;
        forever begin
            @(negedge clk);
            tk = snp_valid && snp_ready && rst_n;
            @(posedge clk);
            #1;
            if (tk) void'(snp_q.pop_front());
            if (snp_q.size() > 0) begin
                snp_valid = 1'b1;
                snp_cmd   = snp_q[0].cmd;
                snp_addr  = snp_q[0].addr;
            end else begin
                snp_valid = 1'b0;
            end
        end
    end

    // LLC responder: raises llc_done in the done_delay-th WAIT cycle unless held.
    initial begin
        int wcnt = 0;
        forever begin
            @(negedge clk);
            if (busy && !llc_eof) wcnt++;
            else wcnt = 0;
            llc_done = busy && !llc_eof && !hold && (wcnt >= done_delay);
        end
    end

    // Grant monitor: every issue strobe must match the next expected grant.
    initial begin
        grant_t exp;
        forever begin
            @(negedge clk);
            if (rst_n && llc_eof) begin
                eof_cnt++;
                eof_cyc = cyc;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_eof got cmd=%0h addr=%h src=%0b, none expected",
                             llc_command, llc_address, grant_src);
                end else begin
                    exp = sb.pop_front();
                    if ({llc_command, llc_address, grant_src} !== exp) begin
                        failures++;
                        $display("FAIL grant got cmd=%0h addr=%h src=%0b exp cmd=%0h addr=%h src=%0b",
                                 llc_command, llc_address, grant_src, exp.cmd, exp.addr, exp.src);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cpu_send(input logic [CW-1:0] c, input logic [AW-1:0] a);
        bit ok = 0;
        @(posedge clk);
        #1;
        cpu_valid = 1'b1;
        cpu_cmd   = c;
        cpu_addr  = a;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (cpu_ready) begin ok = 1; acc_cyc = cyc; break; end
        end
        @(posedge clk);
        #1;
        cpu_valid = 1'b0;
        if (!ok) begin
            checks++; failures++;
            $display("FAIL cpu_accept_timeout got ready=0 exp ready=1");
        end
    endtask

    task automatic wait_busy();
        bit ok = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk); #1;
            if (busy) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL wait_busy got busy=0 exp busy=1"); end
    endtask

    task automatic wait_snpq(input int left);
        bit ok = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk); #1;
            if (snp_q.size() == left) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL snoop_push_timeout got left=%0d exp left=%0d", snp_q.size(), left);
        end
    endtask

    task automatic wait_drain();
        bit ok = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk); #1;
            if (sb.size() == 0 && snp_q.size() == 0 && !busy) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL drain_timeout got pending=%0d exp pending=0", sb.size());
        end
    endtask

    task automatic push_snp(input logic [CW-1:0] c, input logic [AW-1:0] a, input bit expect_grant);
        snp_q.push_back('{cmd: c, addr: a});
        if (expect_grant) sb.push_back('{cmd: c, addr: a, src: 1'b1});
    endtask

    task automatic push_exp_cpu(input logic [CW-1:0] c, input logic [AW-1:0] a);
        sb.push_back('{cmd: c, addr: a, src: 1'b0});
    endtask

    function automatic logic [RW-1:0] out_vec();
        return {cpu_ready, snp_ready, llc_command, llc_address, llc_eof, grant_src,
                busy, snp_full, cmd_err};
    endfunction

    task automatic test_reset();
        logic [RW-1:0] exp = {2'b11, {(RW-2){1'b0}}};
        rst_n = 1'b0;
        #3;
        checks++;
        if (out_vec() !== exp) begin
            failures++; $display("FAIL reset_values got %h exp %h", out_vec(), exp);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        bit seen = 0;
        done_delay = 2;
        push_exp_cpu(4'd0, 32'h0000_1240);
        cpu_send(4'd0, 32'h0000_1240);
        for (int n = 0; n < 10 && eof_cnt == 0; n++) begin @(negedge clk); #1; end
        checks++;
        if (eof_cyc - acc_cyc !== 2) begin
            failures++; $display("FAIL read_latency got %0d exp 2", eof_cyc - acc_cyc);
        end
        for (int n = 0; n < 10; n++) begin
            @(negedge clk); #1;
            if (llc_done) begin seen = 1; break; end
        end
        checks++;
        if (!seen || cyc - eof_cyc !== 2 || busy !== 1'b1) begin
            failures++;
            $display("FAIL done_timing got seen=%0b dist=%0d busy=%0b exp 1 2 1", seen, cyc - eof_cyc, busy);
        end
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL busy_drop got %0b exp 0", busy); end
        wait_drain();
        done_delay = 1;
    endtask

    task automatic test_priority();
        hold = 1'b1;
        push_exp_cpu(4'd0, 32'h0000_00A0);
        cpu_send(4'd0, 32'h0000_00A0);
        wait_busy();
        for (int i = 0; i < 3; i++) push_snp(CW'(3 + i), AW'(32'h100 + i), 1'b1);
        push_exp_cpu(4'd1, 32'h0000_0B00);
        for (int i = 3; i < 6; i++) push_snp(CW'(3 + i % 4), AW'(32'h100 + i), 1'b1);
        wait_snpq(2);
        cpu_send(4'd1, 32'h0000_0B00);
        hold = 1'b0;
        wait_drain();
    endtask

    task automatic test_fifo_full();
        hold = 1'b1;
        push_exp_cpu(4'd2, 32'h0000_0C00);
        cpu_send(4'd2, 32'h0000_0C00);
        wait_busy();
        for (int i = 0; i < 4; i++) push_snp(4'd4, AW'(32'h200 + i), 1'b1);
        wait_snpq(0);
        @(negedge clk); #1;
        checks++;
        if ({snp_full, snp_ready} !== 2'b10) begin
            failures++; $display("FAIL fifo_full got full/ready=%b exp 10", {snp_full, snp_ready});
        end
        push_snp(4'd5, 32'h0000_0204, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (snp_q.size() !== 1 || snp_ready !== 1'b0) begin
            failures++;
            $display("FAIL fifo_holdoff got left=%0d ready=%0b exp left=1 ready=0", snp_q.size(), snp_ready);
        end
        hold = 1'b0;
        for (int n = 0; n < 20 && eof_cnt == 0; n++) begin @(negedge clk); #1; end
        begin
            int base = eof_cnt;
            for (int n = 0; n < 20 && eof_cnt == base; n++) begin @(negedge clk); #1; end
        end
        checks++;
        if (snp_ready !== 1'b1 || snp_q.size() !== 1) begin
            failures++;
            $display("FAIL pop_frees_slot got ready=%0b left=%0d exp ready=1 left=1", snp_ready, snp_q.size());
        end
        @(negedge clk); #1;
        checks++;
        if (snp_q.size() !== 0 || snp_full !== 1'b1) begin
            failures++;
            $display("FAIL fifth_accept got left=%0d full=%0b exp left=0 full=1", snp_q.size(), snp_full);
        end
        wait_drain();
    endtask

    task automatic test_clear_waits();
        hold = 1'b1;
        push_exp_cpu(4'd2, 32'h0000_0D00);
        cpu_send(4'd2, 32'h0000_0D00);
        wait_busy();
        for (int i = 0; i < 4; i++) push_snp(4'd6, AW'(32'h300 + i), 1'b1);
        push_exp_cpu(4'd8, 32'h0000_0E00);
        wait_snpq(0);
        cpu_send(4'd8, 32'h0000_0E00);
        hold = 1'b0;
        wait_drain();
    endtask

    task automatic test_illegal();
        int base = eof_cnt;
        int pulses = 0;
        @(negedge clk);
        push_snp(4'd2, 32'h0000_0F00, 1'b0);
        cpu_send(4'd7, 32'h0000_0F04);
        for (int n = 0; n < 6; n++) begin
            @(negedge clk); #1;
            if (cmd_err) pulses++;
        end
        checks++;
        if (pulses !== 1) begin failures++; $display("FAIL cmd_err_pulses got %0d exp 1", pulses); end
        checks++;
        if (eof_cnt !== base || cpu_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL illegal_dropped got eofs=%0d ready=%0b busy=%0b exp eofs=%0d 1 0",
                     eof_cnt - base, cpu_ready, busy, 0);
        end
`ifdef LLC_ARB_STATS_EN
        checks++;
        if (drop_count !== 32'd2) begin
            failures++; $display("FAIL drop_count got %0d exp 2", drop_count);
        end
`endif
    endtask

    task automatic test_reset_mid_wait();
        logic [RW-1:0] exp = {2'b11, {(RW-2){1'b0}}};
        int base;
        hold = 1'b1;
        push_snp(4'd4, 32'hDEAD_0000, 1'b1);
        wait_busy();
        for (int i = 0; i < 3; i++) push_snp(4'd3, AW'(32'h400 + i), 1'b0);
        wait_snpq(0);
        @(negedge clk); #1;
        checks++;
        if ({busy, grant_src, llc_address} !== {2'b11, 32'hDEAD_0000}) begin
            failures++;
            $display("FAIL pre_reset_wait got busy=%0b src=%0b addr=%h exp 1 1 dead0000",
                     busy, grant_src, llc_address);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_vec() !== exp) begin
            failures++; $display("FAIL async_reset got %h exp %h", out_vec(), exp);
        end
        hold = 1'b0;
        base = eof_cnt;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (eof_cnt !== base || busy !== 1'b0 || snp_full !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_quiet got eofs=%0d busy=%0b full=%0b exp 0 0 0",
                     eof_cnt - base, busy, snp_full);
        end
        push_exp_cpu(4'd1, 32'h0000_5550);
        cpu_send(4'd1, 32'h0000_5550);
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_priority();
        test_fifo_full();
        test_clear_waits();
        test_illegal();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
